evac_dispatcher: RTL

Read side of the evacuation queue. Pops one entry at a time (zone and priority) through the queue's `Serve` strobe and picks a free rescue unit. It then offers the entry to that unit with a valid/ack handshake. If a unit fails to acknowledge within a bounded number of cycles, the entry is retried on another unit. Sits between the evacuation queue and the rescue-unit interface.

---
 rtl/evac_pkg.sv | 14 +
 rtl/free_unit_arbiter.sv | 27 ++
 rtl/evac_dispatcher.sv | 137 +++++++++++++
 3 files changed

// File: rtl/evac_pkg.sv
// rtl/evac_pkg.sv - shared widths and FSM state type for the evacuation dispatcher
package evac_pkg;

   localparam int ZONE_W = 8;
   localparam int PRIO_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      SELECT = 2'd2,
      OFFER  = 2'd3
   } evac_disp_state_t;

endpackage

// File: rtl/free_unit_arbiter.sv
// rtl/free_unit_arbiter.sv - lowest-index picker over units that are free and not yet failed
module free_unit_arbiter #(
   parameter int NUM_UNITS = 4
) (
   input  logic [NUM_UNITS-1:0]         unit_busy,
   input  logic [NUM_UNITS-1:0]         fail_mask,
   output logic                         found,
   output logic [$clog2(NUM_UNITS)-1:0] idx
);

   logic [NUM_UNITS-1:0] cand;

   assign cand = ~unit_busy & ~fail_mask;

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         if (cand[i]) begin
            found = 1'b1;
            idx   = ($clog2(NUM_UNITS))'(i);
         end
      end
   end

endmodule

// File: rtl/evac_dispatcher.sv
// rtl/evac_dispatcher.sv - pops queue entries and offers each to a free rescue unit, retrying on ack timeout
module evac_dispatcher
   import evac_pkg::*;
#(
   parameter int NUM_UNITS   = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                         Main_Clock,
   input  logic                         rst_n,
   input  logic                         Enable,
   input  logic                         Queue_Empty,
   input  logic [ZONE_W-1:0]            Queue_Zone,
   input  logic [PRIO_W-1:0]            Queue_Priority,
   output logic                         Serve,
   input  logic [NUM_UNITS-1:0]         Unit_Busy,
   output logic                         Dispatch_Valid,
   output logic [$clog2(NUM_UNITS)-1:0] Dispatch_Unit,
   output logic [ZONE_W-1:0]            Dispatch_Zone,
   output logic [PRIO_W-1:0]            Dispatch_Priority,
   input  logic                         Dispatch_Ack,
   output logic [7:0]                   Dispatch_Count,
   output logic                         Timeout_Error
);

   localparam int         IDX_W      = $clog2(NUM_UNITS);
   localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

   evac_disp_state_t     state_q, state_d;
   logic                 serve_q, serve_d;
   logic [ZONE_W-1:0]    zone_q, zone_d;
   logic [PRIO_W-1:0]    prio_q, prio_d;
   logic [IDX_W-1:0]     unit_q, unit_d;
   logic [7:0]           timer_q, timer_d;
   logic [NUM_UNITS-1:0] fail_q, fail_d;
   logic [7:0]           count_q, count_d;
   logic                 terr_q, terr_d;

   logic                 arb_found;
   logic [IDX_W-1:0]     arb_idx;

   free_unit_arbiter #(
      .NUM_UNITS (NUM_UNITS)
   ) u_arb (
      .unit_busy (Unit_Busy),
      .fail_mask (fail_q),
      .found     (arb_found),
      .idx       (arb_idx)
   );

   always_comb begin
      state_d = state_q;
      serve_d = 1'b0;
      zone_d  = zone_q;
      prio_d  = prio_q;
      unit_d  = unit_q;
      timer_d = timer_q;
      fail_d  = fail_q;
      count_d = count_q;
      terr_d  = terr_q;
      case (state_q)
         IDLE: begin
            if (Enable && !Queue_Empty) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            // Queue may have been cleared since IDLE looked at it.
            if (Queue_Empty) begin
               state_d = IDLE;
            end else begin
               serve_d = 1'b1;
               zone_d  = Queue_Zone;
               prio_d  = Queue_Priority;
               fail_d  = '0;
               state_d = SELECT;
            end
         end
         SELECT: begin
            if (arb_found) begin
               unit_d  = arb_idx;
               timer_d = '0;
               state_d = OFFER;
            end else if (|fail_q) begin
               fail_d = '0;
            end
         end
         OFFER: begin
            if (Dispatch_Ack) begin
               if (count_q != 8'hFF) begin
                  count_d = count_q + 8'd1;
               end
               state_d = IDLE;
            end else if (timer_q == TIMER_LAST) begin
               terr_d         = 1'b1;
               fail_d[unit_q] = 1'b1;
               state_d        = SELECT;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Main_Clock) begin
      if (!rst_n) begin
         state_q <= IDLE;
         serve_q <= 1'b0;
         zone_q  <= '0;
         prio_q  <= '0;
         unit_q  <= '0;
         timer_q <= '0;
         fail_q  <= '0;
         count_q <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         serve_q <= serve_d;
         zone_q  <= zone_d;
         prio_q  <= prio_d;
         unit_q  <= unit_d;
         timer_q <= timer_d;
         fail_q  <= fail_d;
         count_q <= count_d;
         terr_q  <= terr_d;
      end
   end

   assign Serve             = serve_q;
   assign Dispatch_Valid    = (state_q == OFFER);
   assign Dispatch_Unit     = unit_q;
   assign Dispatch_Zone     = zone_q;
   assign Dispatch_Priority = prio_q;
   assign Dispatch_Count    = count_q;
   assign Timeout_Error     = terr_q;

endmodule
